// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32x32 MIPS register file: two async read ports, one sync write port, debug port, write counter
// Optional macro REGFILE_WB_BYPASS_EN: same-cycle writeback forwarding onto read ports A and B.
module reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [CNT_W-1:0]  wr_count,
    output logic              wr_zero_err
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr_commit;

    // $0 is hardwired: writes to it are dropped, so only non-zero targets commit
    assign wr_commit = wr_en && (wr_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_commit) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_a = (rd_addr_a == '0) ? '0 : regs[rd_addr_a];
`ifdef REGFILE_WB_BYPASS_EN
        if (wr_commit && (rd_addr_a == wr_addr)) begin
            rd_data_a = wr_data;
        end
`endif
    end

    always_comb begin
        rd_data_b = (rd_addr_b == '0) ? '0 : regs[rd_addr_b];
`ifdef REGFILE_WB_BYPASS_EN
        if (wr_commit && (rd_addr_b == wr_addr)) begin
            rd_data_b = wr_data;
        end
`endif
    end

    // Debug port samples the pre-write array and is never forwarded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_data <= '0;
        end else begin
            dbg_data <= (dbg_addr == '0) ? '0 : regs[dbg_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count <= '0;
        end else if (wr_commit && (wr_count != {CNT_W{1'b1}})) begin
            wr_count <= wr_count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_zero_err <= 1'b0;
        end else if (wr_en && (wr_addr == '0)) begin
            wr_zero_err <= 1'b1;
        end
    end
endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- 32 x 32-bit MIPS general-purpose register file.
- Sits directly downstream of the 5-bit register-destination select mux. That mux's output (rt or rd) drives wr_addr; the writeback data and RegWrite from the WB stage drive wr_data and wr_en.
- Two asynchronous read ports feed the ID stage operand latches. One synchronous write port.
- A debug read port and a committed-write counter support bench and board inspection.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W = 32.
- CNT_W, 16, width of the committed-write counter.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  RegWrite from WB; commits on the rising clk edge when high.
- wr_addr  input  ADDR_W  destination register from the RegDst select mux.
- wr_data  input  DATA_W  writeback value (ALU result or load data).
- rd_addr_a  input  ADDR_W  rs read address.
- rd_data_a  output  DATA_W  rs read data, combinational.
- rd_addr_b  input  ADDR_W  rt read address.
- rd_data_b  output  DATA_W  rt read data, combinational.
- dbg_addr  input  ADDR_W  debug read address.
- dbg_data  output  DATA_W  debug read data, registered (1-cycle latency).
- wr_count  output  CNT_W  number of committed writes to non-zero registers, saturating.
- wr_zero_err  output  1  sticky flag; set when a write to $0 is attempted.

Behaviour:
- Reset (rst_n low, asynchronous, no clock needed):
  - all 32 registers = 0;
  - dbg_data = 0, wr_count = 0, wr_zero_err = 0.
  - Held for the entire time rst_n is low. Reset asserted mid-write discards that write.
- Write:
  - On a rising clk edge with wr_en=1 and wr_addr!=0, regs[wr_addr] <= wr_data. Visible to non-bypassed reads from the next cycle.
  - Writes with wr_en=0 have no effect.
- Register $0:
  - Always reads 0 on every port.
  - A write with wr_en=1 and wr_addr=0 is dropped and does not increment wr_count. It sets wr_zero_err=1, which stays set until reset.
- Read ports A/B:
  - Purely combinational from regs[rd_addr].
  - Both ports may address the same register simultaneously; both return the same value.
- Read-during-write (rd_addr == wr_addr != 0, wr_en=1, same cycle): without the optional feature, returns the OLD stored value.
- Debug port:
  - dbg_data <= (dbg_addr==0) ? 0 : regs[dbg_addr] each rising edge.
  - Samples pre-write contents; a same-cycle write appears one cycle later.
  - Never bypassed.
- wr_count:
  - Increments by 1 on each committed non-zero write.
  - Saturates at 2**CNT_W-1 and does not wrap.
  - A write of an identical value still counts.
- No internal FSM beyond the storage, counter and sticky flag. All updates are single-cycle.

Optional Feature:
- Macro REGFILE_WB_BYPASS_EN.
- Defined: internal write-before-read forwarding on ports A and B.
  - When wr_en=1, wr_addr!=0 and rd_addr_x==wr_addr, rd_data_x = wr_data combinationally in the same cycle.
  - This lets the ID stage read a value being written back that cycle without an extra forwarding path.
  - $0 is still forced to 0.
  - The debug port is unaffected.
- Not defined: no bypass; same-cycle reads return the old value as described above.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-cycle after loading regs -> all rd_data, dbg_data and wr_count read 0 immediately; wr_zero_err=0.
- Basic write/read: write 0xDEADBEEF to r8 at cycle 1 -> rd_addr_a=8 reads 0xDEADBEEF from cycle 2; rd_addr_b=9 reads 0; wr_count=1.
- $0 protection: wr_en=1, wr_addr=0, wr_data=0x12345678 -> rd_data_a(addr 0)=0, wr_count unchanged, wr_zero_err=1 and stays 1 through 10 further idle cycles.
- Read-during-write: r5=0x00000011, then write r5=0x00000022 with rd_addr_a=5 in the same cycle -> rd_data_a=0x11 without the macro, 0x22 with REGFILE_WB_BYPASS_EN; both builds read 0x22 the next cycle.
- Debug latency and dual read: write r31=0xA5A5A5A5, set dbg_addr=31 and rd_addr_a=rd_addr_b=31 -> rd_data_a=rd_data_b=0xA5A5A5A5; dbg_data=0xA5A5A5A5 one cycle after the sampling edge.
- Counter saturation: CNT_W=4, perform 20 writes to r1..r20 -> wr_count stops at 15 and holds; all 20 registers hold their written values.
